// File: rtl/fp_mul_unpack.sv
// fp_mul_unpack -- front end of the pipelined FP32 multiplier.
//
// Accepts an IEEE-754 single-precision operand pair over valid/ready and
// emits each operand unpacked (biased exponent, mantissa with explicit
// hidden bit, class flags) plus the product sign and the special-case result
// flags. Two-register elastic pipeline (p1 = raw operands, p2 = decoded
// output) with bubble collapsing and back-pressure; capacity two pairs.
//
// Configuration macro: FP_UNPACK_SUBNORM_EN
//   defined   : subnormals are passed through (exp = 1, mant = {0, F}).
//   undefined : denormals-are-zero (subnormal treated as a signed zero).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand pair handshake (in_ready is combinational
//                         from out_ready)
//   a_in, b_in            raw IEEE-754 operands
//   out_valid / out_ready result handshake
//   sign_out              a.sign ^ b.sign
//   a_exp, b_exp          9-bit biased exponents, zero-extended
//   a_mant, b_mant        24-bit mantissas {hidden, frac}
//   a_cls, b_cls          class {nan, inf, zero, subnormal}
//   res_nan/inf/zero      product special-case flags
module fp_mul_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_in,
    input  logic [EXP_W+MAN_W:0]   b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign_out,
    output logic [EXP_W:0]         a_exp,
    output logic [EXP_W:0]         b_exp,
    output logic [MAN_W:0]         a_mant,
    output logic [MAN_W:0]         b_mant,
    output logic [3:0]             a_cls,
    output logic [3:0]             b_cls,
    output logic                   res_nan,
    output logic                   res_inf,
    output logic                   res_zero
);

    localparam int W = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [EXP_W:0] exp;
        logic [MAN_W:0] mant;
        logic           nan;
        logic           inf;
        logic           zero;
        logic           sub;
    } op_t;

    function automatic op_t unpack_op(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        op_t              r;
        e = x[W-2:MAN_W];
        f = x[MAN_W-1:0];
        r = '0;
        if (&e) begin
            r.exp  = {1'b0, e};
            r.mant = {1'b0, f};
            r.nan  = |f;
            r.inf  = ~|f;
        end else if (~|e) begin
            if (~|f) begin
                r.zero = 1'b1;
            end else begin
`ifdef FP_UNPACK_SUBNORM_EN
                // Subnormals carry the minimum exponent with no hidden bit.
                r.exp  = {{EXP_W{1'b0}}, 1'b1};
                r.mant = {1'b0, f};
                r.sub  = 1'b1;
`else
                // Flushed to zero; fields stay zero, sign is kept by caller.
                r.zero = 1'b1;
`endif
            end
        end else begin
            r.exp  = {1'b0, e};
            r.mant = {1'b1, f};
        end
        return r;
    endfunction

    // Returns {nan, inf, zero} for the product of two classified operands.
    function automatic logic [2:0] result_flags(input op_t a, input op_t b);
        logic n;
        logic i;
        logic z;
        n = a.nan | b.nan | (a.inf & b.zero) | (b.inf & a.zero);
        i = !n & (a.inf | b.inf);
        z = !n & !i & (a.zero | b.zero);
        return {n, i, z};
    endfunction

    logic           vld_p1;
    logic [W-1:0]   a_p1;
    logic [W-1:0]   b_p1;
    logic           vld_p2;
    logic           load_p1;
    logic           load_p2;
    op_t            a_dec;
    op_t            b_dec;
    logic [2:0]     flags_dec;

    // p2 refills whenever it is empty or draining; p1 refills whenever it is
    // empty or moving into p2 (this is what collapses bubbles).
    assign load_p2  = !vld_p2 | out_ready;
    assign load_p1  = !vld_p1 | load_p2;
    assign in_ready = rst_n & load_p1;

    // ---- stage p1: register raw operands ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else if (load_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                a_p1 <= a_in;
                b_p1 <= b_in;
            end
        end
    end

    always_comb begin
        a_dec     = unpack_op(a_p1);
        b_dec     = unpack_op(b_p1);
        flags_dec = result_flags(a_dec, b_dec);
    end

    // ---- stage p2: decoded output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            sign_out <= 1'b0;
            a_exp    <= '0;
            b_exp    <= '0;
            a_mant   <= '0;
            b_mant   <= '0;
            a_cls    <= '0;
            b_cls    <= '0;
            res_nan  <= 1'b0;
            res_inf  <= 1'b0;
            res_zero <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sign_out <= a_p1[W-1] ^ b_p1[W-1];
                a_exp    <= a_dec.exp;
                b_exp    <= b_dec.exp;
                a_mant   <= a_dec.mant;
                b_mant   <= b_dec.mant;
                a_cls    <= {a_dec.nan, a_dec.inf, a_dec.zero, a_dec.sub};
                b_cls    <= {b_dec.nan, b_dec.inf, b_dec.zero, b_dec.sub};
                {res_nan, res_inf, res_zero} <= flags_dec;
            end
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_fp_mul_unpack.sv
module tb_fp_mul_unpack;

    typedef logic [77:0] rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic [8:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    logic [3:0]  a_cls, b_cls;
    logic        res_nan, res_inf, res_zero;

    rec_t        obs;
    rec_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 1'b0;

    fp_mul_unpack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_mant(a_mant), .b_mant(b_mant),
        .a_cls(a_cls), .b_cls(b_cls),
        .res_nan(res_nan), .res_inf(res_inf), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    assign obs = {sign_out, a_exp, b_exp, a_mant, b_mant, a_cls, b_cls,
                  res_nan, res_inf, res_zero};

    function automatic rec_t mk(input logic s, input logic [8:0] ae, input logic [8:0] be,
                                input logic [23:0] am, input logic [23:0] bm,
                                input logic [3:0] ac, input logic [3:0] bc,
                                input logic n, input logic i, input logic z);
        return {s, ae, be, am, bm, ac, bc, n, i, z};
    endfunction

    // {exp[8:0], mant[23:0], cls[3:0]}
    function automatic logic [36:0] model_op(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == 8'hFF) return {1'b0, e, 1'b0, f, (f != 0), (f == 0), 2'b00};
        if (e == 8'h00 && f == 0) return {9'd0, 24'd0, 4'b0010};
`ifdef FP_UNPACK_SUBNORM_EN
        if (e == 8'h00) return {9'd1, 1'b0, f, 4'b0001};
`else
        if (e == 8'h00) return {9'd0, 24'd0, 4'b0010};
`endif
        return {1'b0, e, 1'b1, f, 4'b0000};
    endfunction

    function automatic rec_t model(input logic [31:0] a, input logic [31:0] b);
        logic [36:0] oa, ob;
        logic n, i, z;
        oa = model_op(a);
        ob = model_op(b);
        n = oa[3] | ob[3] | (oa[2] & ob[1]) | (ob[2] & oa[1]);
        i = !n & (oa[2] | ob[2]);
        z = !n & !i & (oa[1] | ob[1]);
        return {a[31] ^ b[31], oa[36:28], ob[36:28], oa[27:4], ob[27:4],
                oa[3:0], ob[3:0], n, i, z};
    endfunction

    task automatic chk(input string tag, input rec_t o, input rec_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Output side of the scoreboard: every completed handshake pops one entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output observed=%h expected=none", obs);
            end else begin
                chk("output", obs, sbq.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input rec_t e);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout observed=in_ready_low expected=accept");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 50 && (sbq.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", rec_t'(sbq.size()), rec_t'(0));
    endtask

    logic [31:0] sp[10];
    rec_t        snap;
    logic [31:0] ra, rb;

    initial begin
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
               32'h00000001, 32'h807FFFFF, 32'h3F800000, 32'h00800000, 32'h7F7FFFFF};

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("reset_outputs", obs, '0);
        chk("reset_out_valid", rec_t'(out_valid), rec_t'(0));
        chk("reset_in_ready", rec_t'(in_ready), rec_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", rec_t'(in_ready), rec_t'(1));
        @(posedge clk);
        #1;

        // Normal pair with latency check
        out_ready = 1'b1;
        send(32'h3FC00000, 32'hC0000000,
             mk(1'b1, 9'h07F, 9'h080, 24'hC00000, 24'h800000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
        chk("latency_edge1", rec_t'(out_valid), rec_t'(0));
        @(posedge clk);
        #1;
        chk("latency_edge2", rec_t'(out_valid), rec_t'(1));
        drain();

        // Inf x zero
        send(32'h7F800000, 32'h00000000,
             mk(1'b0, 9'h0FF, 9'h000, 24'h000000, 24'h000000, 4'b0100, 4'b0010, 1'b1, 1'b0, 1'b0));
        drain();

        // Subnormal operand
`ifdef FP_UNPACK_SUBNORM_EN
        send(32'h00000001, 32'h3F800000,
             mk(1'b0, 9'h001, 9'h07F, 24'h000001, 24'h800000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0));
`else
        send(32'h00000001, 32'h3F800000,
             mk(1'b0, 9'h000, 9'h07F, 24'h000000, 24'h800000, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1));
`endif
        drain();

        // NaN operand
        send(32'h7FC00000, 32'h3F800000,
             mk(1'b0, 9'h0FF, 9'h07F, 24'h400000, 24'h800000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0));
        drain();

        // Back-pressure: four pairs, out_ready low for three cycles
        out_ready = 1'b1;
        send(32'h40400000, 32'h40A00000, model(32'h40400000, 32'h40A00000));
        send(32'hBF000000, 32'h41200000, model(32'hBF000000, 32'h41200000));
        chk("bp_first_valid", rec_t'(out_valid), rec_t'(1));
        out_ready = 1'b0;
        snap = obs;
        in_valid = 1'b1;
        a_in = 32'h42C80000;
        b_in = 32'hC2480000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", rec_t'(in_ready), rec_t'(0));
            chk("bp_out_valid_held", rec_t'(out_valid), rec_t'(1));
            chk("bp_outputs_stable", obs, snap);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h42C80000, 32'hC2480000, model(32'h42C80000, 32'hC2480000));
        send(32'h3E800000, 32'h3E800000, model(32'h3E800000, 32'h3E800000));
        drain();

        // Mixed operands under random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 1) != 0) ? sp[$urandom_range(0, 9)] : $urandom;
            rb = ($urandom_range(0, 1) != 0) ? sp[$urandom_range(0, 9)] : $urandom;
            send(ra, rb, model(ra, rb));
        end
        rand_ready = 1'b0;
        drain();

        // Reset while both stages are full
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, model(32'h3F800000, 32'h40000000));
        send(32'hC0400000, 32'h7F800000, model(32'hC0400000, 32'h7F800000));
        chk("mid_reset_full", rec_t'({out_valid, in_ready}), rec_t'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", obs, '0);
        chk("mid_reset_out_valid", rec_t'(out_valid), rec_t'(0));
        chk("mid_reset_in_ready", rec_t'(in_ready), rec_t'(0));
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_empty", rec_t'(out_valid), rec_t'(0));
        end
        @(posedge clk);
        #1;
        send(32'hC1100000, 32'h00400000, model(32'hC1100000, 32'h00400000));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
